// File: rtl/udp_fragment_generator.sv
// Splits one outbound datagram into IP fragments: one header descriptor per
// fragment followed by its payload bytes (bit 8 flags the first byte).
module udp_fragment_generator #(
  parameter int unsigned MAX_FRAGMENT_BYTES = 1480
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        packet_valid,
  input  logic [15:0] packet_length,
  input  logic [15:0] packet_id,
  output logic        packet_ready,
  input  logic [7:0]  data,
  input  logic        data_enable,
  input  logic        data_last,
  output logic        ready,
  output logic        header_valid,
  input  logic        header_enable,
  output logic [15:0] fragment_id,
  output logic [12:0] fragment_offset,
  output logic        fragment_more,
  output logic [15:0] fragment_length,
  output logic [8:0]  push_data,
  output logic        push_data_valid,
  output logic        push_data_last,
  input  logic        push_data_enable,
  output logic        length_error
);

  localparam int unsigned LEN_W = 16;
  localparam int unsigned OFF_W = 13;
  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MAX_FRAGMENT_BYTES);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_HEADER  = 2'd1;
  localparam logic [1:0] S_PAYLOAD = 2'd2;
  localparam logic [1:0] S_DRAIN   = 2'd3;

  logic [1:0]       state, state_nxt;
  logic [LEN_W-1:0] pkt_len, pkt_len_nxt;
  logic [LEN_W-1:0] sent, sent_nxt;
  logic [LEN_W-1:0] frag_left, frag_left_nxt;
  logic [LEN_W-1:0] rem_nxt;
  logic             first_pending, first_pending_nxt;

  logic             header_valid_nxt;
  logic [LEN_W-1:0] fragment_id_nxt;
  logic [OFF_W-1:0] fragment_offset_nxt;
  logic             fragment_more_nxt;
  logic [LEN_W-1:0] fragment_length_nxt;
  logic [8:0]       push_data_nxt;
  logic             push_data_valid_nxt;
  logic             push_data_last_nxt;
  logic             length_error_nxt;

  logic out_free;
  logic byte_accept;
  logic last_counted;

  // Output slot can take a new byte when empty or being drained this cycle.
  assign out_free     = !push_data_valid || push_data_enable;
  assign ready        = (state == S_PAYLOAD) && (frag_left != '0) && out_free;
  assign packet_ready = (state == S_IDLE);
  assign byte_accept  = data_enable && ready;
  // The final fragment covers the rest of the datagram, so its last byte is the last counted byte.
  assign last_counted = (frag_left == LEN_W'(1)) && !fragment_more;

  always_comb begin
    state_nxt           = state;
    pkt_len_nxt         = pkt_len;
    sent_nxt            = sent;
    frag_left_nxt       = frag_left;
    first_pending_nxt   = first_pending;
    fragment_id_nxt     = fragment_id;
    fragment_offset_nxt = fragment_offset;
    fragment_more_nxt   = fragment_more;
    fragment_length_nxt = fragment_length;
    push_data_nxt       = push_data;
    push_data_valid_nxt = push_data_valid && !push_data_enable;
    push_data_last_nxt  = push_data_last;
    length_error_nxt    = 1'b0;
    rem_nxt             = '0;

    case (state)
      S_IDLE: begin
        if (packet_valid) begin
          pkt_len_nxt     = packet_length;
          fragment_id_nxt = packet_id;
          sent_nxt        = '0;
          state_nxt       = S_HEADER;
        end
      end
      S_HEADER: begin
        if (header_enable) begin
          frag_left_nxt     = fragment_length;
          first_pending_nxt = 1'b1;
          state_nxt         = (fragment_length == '0) ? S_IDLE : S_PAYLOAD;
        end
      end
      S_PAYLOAD: begin
        if (byte_accept) begin
          push_data_nxt       = {first_pending, data};
          push_data_valid_nxt = 1'b1;
          push_data_last_nxt  = (frag_left == LEN_W'(1)) || data_last;
          first_pending_nxt   = 1'b0;
          frag_left_nxt       = frag_left - LEN_W'(1);
          if (data_last && !last_counted) begin
            // Upstream ended early: close out here and drop remaining fragments.
            length_error_nxt = 1'b1;
            frag_left_nxt    = '0;
            state_nxt        = S_DRAIN;
          end else if (frag_left == LEN_W'(1)) begin
            sent_nxt = sent + fragment_length;
            if (last_counted) begin
              length_error_nxt = !data_last;
              state_nxt        = S_DRAIN;
            end else begin
              state_nxt = S_HEADER;
            end
          end
        end
      end
      S_DRAIN: begin
        if (out_free) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase

    // Descriptor fields are computed once on entry to S_HEADER and held until accepted.
    header_valid_nxt = (state_nxt == S_HEADER);
    if (state_nxt == S_HEADER) begin
      rem_nxt             = pkt_len_nxt - sent_nxt;
      fragment_more_nxt   = (rem_nxt > MAX_LEN);
      fragment_length_nxt = (rem_nxt > MAX_LEN) ? MAX_LEN : rem_nxt;
      fragment_offset_nxt = sent_nxt[LEN_W-1:3];
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state           <= S_IDLE;
      pkt_len         <= '0;
      sent            <= '0;
      frag_left       <= '0;
      first_pending   <= 1'b0;
      header_valid    <= 1'b0;
      fragment_id     <= '0;
      fragment_offset <= '0;
      fragment_more   <= 1'b0;
      fragment_length <= '0;
      push_data       <= '0;
      push_data_valid <= 1'b0;
      push_data_last  <= 1'b0;
      length_error    <= 1'b0;
    end else begin
      state           <= state_nxt;
      pkt_len         <= pkt_len_nxt;
      sent            <= sent_nxt;
      frag_left       <= frag_left_nxt;
      first_pending   <= first_pending_nxt;
      header_valid    <= header_valid_nxt;
      fragment_id     <= fragment_id_nxt;
      fragment_offset <= fragment_offset_nxt;
      fragment_more   <= fragment_more_nxt;
      fragment_length <= fragment_length_nxt;
      push_data       <= push_data_nxt;
      push_data_valid <= push_data_valid_nxt;
      push_data_last  <= push_data_last_nxt;
      length_error    <= length_error_nxt;
    end
  end

endmodule

// File: tb/tb_udp_fragment_generator.sv
// Scoreboard bench for udp_fragment_generator: expected descriptors and bytes
// are derived from datagram length arithmetic and checked by a monitor.
module tb_udp_fragment_generator;

  localparam int MAX = 1480;

  typedef struct packed {
    logic [15:0] id;
    logic [12:0] off;
    logic        more;
    logic [15:0] len;
  } hdr_t;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        packet_valid = 1'b0;
  logic [15:0] packet_length = '0;
  logic [15:0] packet_id = '0;
  logic        packet_ready;
  logic [7:0]  data = '0;
  logic        data_enable = 1'b0;
  logic        data_last = 1'b0;
  logic        ready;
  logic        header_valid;
  logic        header_enable = 1'b1;
  logic [15:0] fragment_id;
  logic [12:0] fragment_offset;
  logic        fragment_more;
  logic [15:0] fragment_length;
  logic [8:0]  push_data;
  logic        push_data_valid;
  logic        push_data_last;
  logic        push_data_enable = 1'b1;
  logic        length_error;

  int   checks = 0;
  int   failures = 0;
  int   err_seen = 0;
  bit   stall = 1'b0;
  hdr_t hq[$];
  logic [9:0] bq[$];

  udp_fragment_generator #(.MAX_FRAGMENT_BYTES(MAX)) dut (
    .clock(clock), .reset(reset),
    .packet_valid(packet_valid), .packet_length(packet_length), .packet_id(packet_id),
    .packet_ready(packet_ready),
    .data(data), .data_enable(data_enable), .data_last(data_last), .ready(ready),
    .header_valid(header_valid), .header_enable(header_enable),
    .fragment_id(fragment_id), .fragment_offset(fragment_offset),
    .fragment_more(fragment_more), .fragment_length(fragment_length),
    .push_data(push_data), .push_data_valid(push_data_valid),
    .push_data_last(push_data_last), .push_data_enable(push_data_enable),
    .length_error(length_error)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Downstream handshakes: always enabled, or randomly stalled.
  task automatic enable_driver();
    forever begin
      @(posedge clock);
      #1;
      header_enable    = stall ? ($urandom_range(0, 1) == 1) : 1'b1;
      push_data_enable = stall ? ($urandom_range(0, 3) != 0) : 1'b1;
    end
  endtask

  task automatic monitor();
    logic [9:0] held;
    bit holding;
    hdr_t exp_h;
    logic [9:0] exp_b;
    holding = 1'b0;
    held = '0;
    forever begin
      @(negedge clock);
      if (reset) begin
        holding = 1'b0;
        continue;
      end
      if (header_valid && header_enable) begin
        if (hq.size() == 0) chk("hdr_unexpected", 64'(1), 64'(0));
        else begin
          exp_h = hq.pop_front();
          chk("header", 64'({fragment_id, fragment_offset, fragment_more, fragment_length}), 64'(exp_h));
        end
      end
      if (push_data_valid) begin
        if (holding) chk("stall_hold", 64'({push_data_last, push_data}), 64'(held));
        if (push_data_enable) begin
          holding = 1'b0;
          if (bq.size() == 0) chk("byte_unexpected", 64'(1), 64'(0));
          else begin
            exp_b = bq.pop_front();
            chk("byte", 64'({push_data_last, push_data}), 64'(exp_b));
          end
        end else begin
          holding = 1'b1;
          held = {push_data_last, push_data};
        end
      end else begin
        holding = 1'b0;
      end
      if (length_error) err_seen++;
    end
  endtask

  // last_at: index of byte carrying data_last (>= len means never); abort_after >= 0 stops early.
  task automatic send(input int len, input int id, input int last_at, input bit stall_en,
                      input int abort_after);
    int n;
    int idx;
    int guard;
    int flen;
    bit acc;
    bit exp_err;
    logic [7:0] b;
    logic [7:0] pay[$];
    n = (last_at < len) ? last_at + 1 : len;
    exp_err = (len > 0) && (last_at != len - 1);
    stall = stall_en;
    err_seen = 0;
    if (len == 0) hq.push_back('{16'(id), 13'd0, 1'b0, 16'd0});
    for (int off = 0; off < n; off += MAX) begin
      flen = (len - off > MAX) ? MAX : len - off;
      hq.push_back('{16'(id), 13'(off / 8), (len - off > MAX), 16'(flen)});
    end
    for (int i = 0; i < n; i++) begin
      b = 8'($urandom);
      pay.push_back(b);
      bq.push_back({((i % MAX) == MAX - 1) || (i == len - 1) || (i == last_at), (i % MAX) == 0, b});
    end

    @(posedge clock);
    #1;
    packet_valid = 1'b1;
    packet_length = 16'(len);
    packet_id = 16'(id);
    guard = 0;
    do begin
      @(negedge clock);
      acc = packet_ready;
      @(posedge clock);
      #1;
      guard++;
    end while (!acc && guard < 1000);
    packet_valid = 1'b0;
    chk("request_accept", 64'(acc), 64'(1));

    idx = 0;
    guard = 0;
    while (idx < n && guard < 40000) begin
      if (abort_after >= 0 && idx == abort_after) break;
      data_enable = 1'b1;
      data = pay[idx];
      data_last = (idx == last_at);
      @(negedge clock);
      acc = ready;
      @(posedge clock);
      #1;
      guard++;
      if (acc) idx++;
    end
    data_enable = 1'b0;
    data_last = 1'b0;
    if (abort_after >= 0) return;
    chk("bytes_taken", 64'(idx), 64'(n));

    guard = 0;
    do begin
      @(negedge clock);
      #2;
      guard++;
    end while (!(packet_ready && hq.size() == 0 && bq.size() == 0) && guard < 40000);
    chk("back_to_idle", 64'(packet_ready), 64'(1));
    chk("headers_left", 64'(hq.size()), 64'(0));
    chk("bytes_left", 64'(bq.size()), 64'(0));
    chk("length_error_pulses", 64'(err_seen), exp_err ? 64'(1) : 64'(0));
    repeat (2) @(posedge clock);
  endtask

  initial begin
    int len;
    fork
      monitor();
      enable_driver();
    join_none

    repeat (3) @(posedge clock);
    #1;
    reset = 1'b0;
    @(negedge clock);
    chk("rst_packet_ready", 64'(packet_ready), 64'(1));
    chk("rst_header_valid", 64'(header_valid), 64'(0));
    chk("rst_push_valid", 64'(push_data_valid), 64'(0));
    chk("rst_length_error", 64'(length_error), 64'(0));

    send(100, 'h1234, 99, 1'b0, -1);
    send(3000, 'h0101, 2999, 1'b0, -1);
    send(0, 'h0202, 0, 1'b0, -1);
    send(2000, 'h0303, 1999, 1'b1, -1);
    send(1480, 'h0404, 1479, 1'b1, -1);
    send(1481, 'h0505, 1480, 1'b0, -1);
    send(50, 'h0606, 19, 1'b0, -1);
    send(3000, 'h0707, 1500, 1'b1, -1);
    send(30, 'h0808, 30, 1'b0, -1);

    // Reset in the middle of the second fragment's payload.
    send(3000, 'h55aa, 2999, 1'b0, 1600);
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    hq.delete();
    bq.delete();
    @(negedge clock);
    chk("mid_rst_packet_ready", 64'(packet_ready), 64'(1));
    chk("mid_rst_header_valid", 64'(header_valid), 64'(0));
    chk("mid_rst_push_valid", 64'(push_data_valid), 64'(0));
    chk("mid_rst_ready", 64'(ready), 64'(0));
    send(10, 'h0a0a, 9, 1'b0, -1);

    for (int r = 0; r < 4; r++) begin
      len = int'($urandom_range(1, 3500));
      send(len, int'($urandom_range(0, 65535)), len - 1, 1'b1, -1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
